fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage pipelined CPU: PC register, PC+4 incrementer, next-PC select, IF/ID pipeline register.
//  Consumes the hazard unit's PCWrite / IF_ID_Write / IF_flush and the branch redirect (PCSrc + target) from EX.
//  Drives the instruction-memory address and feeds {PC+4, instruction, valid} to the ID stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction word injected on flush/reset (sll $0,$0,0)
//  CNT_W      16             width of performance counters (FETCH_PERF_CNT_EN only)
// PORTS
//  clk_i            in   1   clock, rising edge
//  rst_i            in   1   asynchronous, active-low reset
//  pc_write_i       in   1   1 = PC may advance; 0 = load-use stall
//  if_id_write_i    in   1   1 = IF/ID captures; 0 = IF/ID holds
//  if_flush_i       in   1   1 = squash instruction entering IF/ID
//  pc_src_i         in   1   1 = take branch_target_i
//  branch_target_i  in   32  redirect address from EX
//  imem_instr_i     in   32  instruction word, combinational read of imem_addr_o
//  imem_addr_o      out  32  current PC (= pc_o)
//  pc_o             out  32  current PC register
//  if_id_pc4_o      out  32  registered PC+4 of instruction in ID
//  if_id_instr_o    out  32  registered instruction in ID
//  if_id_valid_o    out  1   1 = if_id_instr_o is a real fetched instruction
//  stall_cnt_o      out  CNT_W  stall cycles (FETCH_PERF_CNT_EN only)
//  flush_cnt_o      out  CNT_W  flush cycles (FETCH_PERF_CNT_EN only)
// BEHAVIOUR
//  Reset (rst_i=0, async, no clock needed): pc=RESET_PC, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0, counters=0.
//  First posedge after rst_i deasserts fetches RESET_PC; instruction appears on if_id_* one cycle after fetch.
//  PC update each posedge, priority order:
//   1. pc_src_i=1 -> pc <= {branch_target_i[31:2],2'b00} (redirect wins even if pc_write_i=0; stalled load-use
//      instruction in ID is flushed by the hazard unit in the same cycle, so the stall is moot)
//   2. pc_write_i=1 -> pc <= pc+4, wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000)
//   3. else hold
//  IF/ID update each posedge, priority order:
//   1. if_flush_i=1 -> instr<=NOP_INSTR, pc4<=0, valid<=0 (flush beats hold)
//   2. if_id_write_i=1 -> instr<=imem_instr_i, pc4<=pc+4, valid<=1
//   3. else hold all three
//  pc+4 is one shared 32-bit adder; carry discarded. imem_addr_o is combinational from pc register, no extra latency.
//  Stall with if_id_write_i=1 and pc_write_i=0 (not produced by hazard unit) is legal: same instruction re-captured.
//  Mid-operation reset: all state returns to reset values immediately; no partial update on the reset-release edge.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   stall_cnt increments on each posedge with pc_write_i=0 and pc_src_i=0;
//   flush_cnt increments on each posedge with if_flush_i=1;
//   both saturate at all-ones, cleared only by reset.
//  Not defined: stall_cnt_o/flush_cnt_o ports and counter logic absent; no other behaviour change.
// STRUCTURE
//  Shared package cpu_pkg: XLEN=32, NOP_INSTR constant, PC_INC=4.
//  One sub-module: program_counter (PC register + next-PC priority mux + adder, exports pc and pc+4).
//  IF/ID register and optional counters live in fetch_stage.
// TESTING
//  Reset: hold rst_i=0 3 cycles, release -> pc_o=0, if_id_valid_o=0, if_id_instr_o=0; next edge pc_o=4.
//  Sequential fetch: pc_write=if_id_write=1, imem returns 32'h1111_0000+addr -> cycle N if_id_instr=32'h1111_0004, pc4=8.
//  Load-use stall: pc_write=if_id_write=0 one cycle at pc=8 -> pc_o stays 8, if_id_* unchanged; resume -> pc_o=12.
//  Branch: pc_src=1, target=32'h0000_0043, if_flush=1 -> pc_o=32'h40, if_id_valid=0, if_id_instr=NOP.
//  Branch+stall same cycle: pc_src=1, pc_write=0, if_flush=1, if_id_write=0 -> pc_o=target, IF/ID flushed.
//  Wrap + perf: pc=32'hFFFF_FFFC advance -> pc_o=0; with FETCH_PERF_CNT_EN, CNT_W=4, 20 stall cycles -> stall_cnt_o=4'hF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its sub-blocks.
//   XLEN      : datapath width
//   NOP_INSTR : canonical no-op (sll $0,$0,0) injected into squashed pipeline slots
//   PC_INC    : sequential PC step (one 32-bit instruction)
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and the rest of the pipeline.
//   Hazard unit -> fetch : pc_write_i, if_id_write_i, if_flush_i
//   EX -> fetch          : pc_src_i, branch_target_i
//   Imem <-> fetch       : imem_addr_o (address out), imem_instr_i (combinational read data in)
//   Fetch -> ID          : pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o
// Modports:
//   master : the fetch stage (drives the *_o members)
//   slave  : the surrounding pipeline / memory (drives the *_i members)
interface fetch_stage_if;
    import cpu_pkg::*;

    logic            pc_write_i;
    logic            if_id_write_i;
    logic            if_flush_i;
    logic            pc_src_i;
    logic [XLEN-1:0] branch_target_i;
    logic [XLEN-1:0] imem_instr_i;
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] if_id_pc4_o;
    logic [XLEN-1:0] if_id_instr_o;
    logic            if_id_valid_o;

    modport master (
        input  pc_write_i, if_id_write_i, if_flush_i, pc_src_i, branch_target_i, imem_instr_i,
        output imem_addr_o, pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o
    );

    modport slave (
        output pc_write_i, if_id_write_i, if_flush_i, pc_src_i, branch_target_i, imem_instr_i,
        input  imem_addr_o, pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o
    );

endinterface

// File: rtl/program_counter.sv
// Program counter: PC register, the single shared PC+4 adder and the next-PC priority mux.
// Ports:
//   clk_i           : clock, rising edge
//   rst_i           : asynchronous active-low reset, loads RESET_PC
//   pc_write_i      : 1 = advance to PC+4, 0 = hold (load-use stall)
//   pc_src_i        : 1 = redirect to branch_target_i (word aligned); beats pc_write_i
//   branch_target_i : redirect address from EX
//   pc_o            : current PC register
//   pc_plus4_o      : PC + 4, modulo 2^32
module program_counter
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_write_i,
    input  logic            pc_src_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;

    // Low target bits are forced to zero; keep them visibly consumed.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^branch_target_i[1:0];

    // Carry out is dropped, so 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc_q + PC_INC;

    // A redirect wins over a stall: the stalled instruction is squashed in the same cycle.
    always_comb begin
        pc_d = pc_q;
        if (pc_src_i) begin
            pc_d = {branch_target_i[XLEN-1:2], 2'b00};
        end else if (pc_write_i) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter, instruction-memory address, IF/ID pipeline register and
// optional performance counters.
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-low reset
//   bus         : fetch_stage_if.master (hazard controls, branch redirect, imem, IF/ID outputs)
//   stall_cnt_o : saturating count of cycles with pc_write_i=0 and pc_src_i=0
//   flush_cnt_o : saturating count of cycles with if_flush_i=1
// Configuration:
//   FETCH_PERF_CNT_EN : when defined, adds CNT_W, stall_cnt_o, flush_cnt_o and the counter
//                       logic; when undefined they are absent and nothing else changes.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int unsigned     CNT_W     = 16
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fetch_stage_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pc_write_i      (bus.pc_write_i),
        .pc_src_i        (bus.pc_src_i),
        .branch_target_i (bus.branch_target_i),
        .pc_o            (pc),
        .pc_plus4_o      (pc_plus4)
    );

    // Imem is read combinationally in the same cycle as the PC.
    assign bus.imem_addr_o = pc;
    assign bus.pc_o        = pc;

    // IF/ID register
    logic [XLEN-1:0] if_id_pc4_q, if_id_pc4_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;

    // Flush beats hold so a squash is never lost behind a stall.
    always_comb begin
        if_id_pc4_d   = if_id_pc4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (bus.if_flush_i) begin
            if_id_pc4_d   = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (bus.if_id_write_i) begin
            if_id_pc4_d   = pc_plus4;
            if_id_instr_d = bus.imem_instr_i;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if_id_pc4_q   <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign bus.if_id_pc4_o   = if_id_pc4_q;
    assign bus.if_id_instr_o = if_id_instr_q;
    assign bus.if_id_valid_o = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // A redirect overrides a stall, so those cycles are not counted as stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.pc_write_i && !bus.pc_src_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bus.if_flush_i && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected post-edge state.
module tb_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] IMEM_TAG = 32'h1111_0000;
    localparam int unsigned CW       = 4;

    logic clk;
    logic rst_n;

    fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP),
        .CNT_W     (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .bus         (bus),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );
`else
    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );
`endif

    // Instruction memory: word content derived from its address.
    always_comb bus.imem_instr_i = IMEM_TAG + bus.imem_addr_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [3:0]  stall;
        logic [3:0]  flush;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid;
    logic [3:0]  m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_pc4   = 32'h0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_stall = '0;
        m_flush = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    bus.pc_o,          32'h0);
        chk({tag, "_pc4"},   bus.if_id_pc4_o,   32'h0);
        chk({tag, "_instr"}, bus.if_id_instr_o, NOP);
        chk({tag, "_valid"}, {31'b0, bus.if_id_valid_o}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, {28'b0, stall_cnt}, 32'h0);
        chk({tag, "_flush_cnt"}, {28'b0, flush_cnt}, 32'h0);
`endif
    endtask

    // Drive one cycle of controls, push the expected result, clock, pop and compare.
    task automatic cycle(input string tag, input logic pw, input logic iw, input logic fl,
                         input logic ps, input logic [31:0] tgt);
        exp_t e;
        logic [31:0] cur_pc;
        bus.pc_write_i      = pw;
        bus.if_id_write_i   = iw;
        bus.if_flush_i      = fl;
        bus.pc_src_i        = ps;
        bus.branch_target_i = tgt;
        cur_pc = m_pc;
        if (ps)      m_pc = {tgt[31:2], 2'b00};
        else if (pw) m_pc = cur_pc + 32'd4;
        if (fl) begin
            m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (iw) begin
            m_instr = IMEM_TAG + cur_pc; m_pc4 = cur_pc + 32'd4; m_valid = 1'b1;
        end
        if (!pw && !ps && m_stall != 4'hF) m_stall = m_stall + 4'd1;
        if (fl && m_flush != 4'hF)         m_flush = m_flush + 4'd1;
        e = '{pc: m_pc, pc4: m_pc4, instr: m_instr, valid: m_valid,
              stall: m_stall, flush: m_flush};
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_checks++;
        assert (sb.size() != 0) else begin
            n_errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_pc"},    bus.pc_o,          e.pc);
            chk({tag, "_addr"},  bus.imem_addr_o,   e.pc);
            chk({tag, "_pc4"},   bus.if_id_pc4_o,   e.pc4);
            chk({tag, "_instr"}, bus.if_id_instr_o, e.instr);
            chk({tag, "_valid"}, {31'b0, bus.if_id_valid_o}, {31'b0, e.valid});
`ifdef FETCH_PERF_CNT_EN
            chk({tag, "_stall_cnt"}, {28'b0, stall_cnt}, {28'b0, e.stall});
            chk({tag, "_flush_cnt"}, {28'b0, flush_cnt}, {28'b0, e.flush});
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n               = 1'b0;
        bus.pc_write_i      = 1'b0;
        bus.if_id_write_i   = 1'b0;
        bus.if_flush_i      = 1'b0;
        bus.pc_src_i        = 1'b0;
        bus.branch_target_i = 32'h0;
        model_reset();

        // Async reset takes effect before any clock edge
        #1;
        chk_reset("rst_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset("rst_release");

        // Sequential fetch
        cycle("seq0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("seq1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("seq_instr_const", bus.if_id_instr_o, 32'h1111_0004);
        chk("seq_pc4_const",   bus.if_id_pc4_o,   32'h0000_0008);

        // Load-use stall, then resume
        cycle("stall", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("stall_pc_const", bus.pc_o, 32'h0000_0008);
        cycle("resume", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("resume_pc_const", bus.pc_o, 32'h0000_000C);

        // Taken branch with misaligned target
        cycle("branch", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0043);
        chk("branch_pc_const", bus.pc_o, 32'h0000_0040);
        cycle("after_br", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        // Branch coinciding with a stall: redirect and flush still win
        cycle("br_stall", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
        chk("br_stall_pc_const", bus.pc_o, 32'h0000_0100);
        cycle("after_br_stall", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        // IF/ID captures while PC holds: same instruction re-captured
        cycle("recap0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("recap1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // PC wrap
        cycle("to_top", 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        cycle("wrap", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc_const",  bus.pc_o,        32'h0000_0000);
        chk("wrap_pc4_const", bus.if_id_pc4_o, 32'h0000_0000);

        // Long stall drives the stall counter into saturation
        for (int i = 0; i < 20; i++) begin
            cycle("long_stall", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("stall_sat_const", {28'b0, stall_cnt}, 32'h0000_000F);
`endif

        // Reset in the middle of operation, with active controls
        cycle("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        bus.pc_src_i        = 1'b1;
        bus.branch_target_i = 32'h0000_0200;
        bus.pc_write_i      = 1'b1;
        bus.if_id_write_i   = 1'b1;
        #1;
        model_reset();
        chk_reset("rst_mid");
        @(posedge clk);
        #1;
        chk_reset("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("post_rst_instr_const", bus.if_id_instr_o, 32'h1111_0000);
        cycle("post_rst1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
